// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, signed gradient type and absolute-value helper for the Sobel edge detector.
// Optional magnitude output is enabled by defining SOBEL_MAG_OUT_EN.
package sobel_pkg;
    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + 2;
    localparam int MAG_W  = DATA_W + 3;

    typedef logic signed [SUM_W:0] grad_t;

    function automatic logic [SUM_W-1:0] abs_grad(input grad_t g);
        grad_t n;
        n = -g;
        return g[SUM_W] ? n[SUM_W-1:0] : g[SUM_W-1:0];
    endfunction
endpackage

// File: rtl/sobel_if.sv
// sobel_if: window/threshold input and edge-flag output bundle for sobel_module.
// The magnitude signal exists only when SOBEL_MAG_OUT_EN is defined.
interface sobel_if;
    import sobel_pkg::*;
    logic              in_valid;
    logic [DATA_W-1:0] p0, p1, p2, p3, p5, p6, p7, p8;
    logic [DATA_W-1:0] threshold;
    logic              out_valid;
    logic              result;
`ifdef SOBEL_MAG_OUT_EN
    logic [MAG_W-1:0]  magnitude;
    modport master (output in_valid, p0, p1, p2, p3, p5, p6, p7, p8, threshold,
                    input out_valid, result, magnitude);
    modport slave  (input in_valid, p0, p1, p2, p3, p5, p6, p7, p8, threshold,
                    output out_valid, result, magnitude);
`else
    modport master (output in_valid, p0, p1, p2, p3, p5, p6, p7, p8, threshold,
                    input out_valid, result);
    modport slave  (input in_valid, p0, p1, p2, p3, p5, p6, p7, p8, threshold,
                    output out_valid, result);
`endif
endinterface

// File: rtl/sobel_axis_grad.sv
// sobel_axis_grad: 1-2-1 weighted sum of the "plus" line minus that of the "minus" line, as a signed gradient.
module sobel_axis_grad
    import sobel_pkg::*;
(
    input  logic [DATA_W-1:0] a0, a1, a2,
    input  logic [DATA_W-1:0] b0, b1, b2,
    output grad_t             g
);
    logic [SUM_W-1:0] sum_a, sum_b;

    assign sum_a = SUM_W'(a0) + (SUM_W'(a1) << 1) + SUM_W'(a2);
    assign sum_b = SUM_W'(b0) + (SUM_W'(b1) << 1) + SUM_W'(b2);
    assign g     = $signed({1'b0, sum_b}) - $signed({1'b0, sum_a});
endmodule

// File: rtl/sobel_module.sv
// sobel_module: two-stage pipelined 3x3 Sobel edge flag (|Gx|+|Gy| > threshold) with valid tagging.
// Defining SOBEL_MAG_OUT_EN adds a registered magnitude output alongside result.
module sobel_module
    import sobel_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    sobel_if.slave   s
);
    grad_t             gx, gy, gx_q, gy_q;
    logic [DATA_W-1:0] thr_q;
    logic              v1;
    logic [MAG_W-1:0]  mag;

    sobel_axis_grad u_gx (.a0(s.p0), .a1(s.p3), .a2(s.p6), .b0(s.p2), .b1(s.p5), .b2(s.p8), .g(gx));
    sobel_axis_grad u_gy (.a0(s.p0), .a1(s.p1), .a2(s.p2), .b0(s.p6), .b1(s.p7), .b2(s.p8), .g(gy));

    assign mag = MAG_W'(abs_grad(gx_q)) + MAG_W'(abs_grad(gy_q));

    // Datapath registers update on bubbles too; only the flag is qualified by valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gx_q        <= '0;
            gy_q        <= '0;
            thr_q       <= '0;
            v1          <= 1'b0;
            s.out_valid <= 1'b0;
            s.result    <= 1'b0;
`ifdef SOBEL_MAG_OUT_EN
            s.magnitude <= '0;
`endif
        end else begin
            gx_q        <= gx;
            gy_q        <= gy;
            thr_q       <= s.threshold;
            v1          <= s.in_valid;
            s.out_valid <= v1;
            s.result    <= v1 && (mag > MAG_W'(thr_q));
`ifdef SOBEL_MAG_OUT_EN
            s.magnitude <= mag;
`endif
        end
    end
endmodule

// File: tb/tb_sobel_module.sv
// tb_sobel_module: directed and random windows checked against a kernel-convolution reference model.
module tb_sobel_module;
    typedef int win_t[9];
    typedef struct {bit v; bit r; int m;} exp_t;

    localparam int KX[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int KY[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t q[$];

    sobel_if bus ();
    sobel_module dut (.clk(clk), .reset_n(reset_n), .s(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_mag(input win_t w);
        int gx = 0, gy = 0;
        for (int i = 0; i < 9; i++) begin
            gx += KX[i] * w[i];
            gy += KY[i] * w[i];
        end
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
        return w;
    endfunction

    // One clock: apply inputs, advance, then compare against the value due two cycles after its input.
    task automatic cyc(input string tag, input bit rn, input bit v, input win_t w, input int thr);
        exp_t e, z;
        int   m;
        z = '{v: 1'b0, r: 1'b0, m: 0};
        reset_n       = rn;
        bus.in_valid  = v;
        bus.p0 = 8'(w[0]); bus.p1 = 8'(w[1]); bus.p2 = 8'(w[2]); bus.p3 = 8'(w[3]);
        bus.p5 = 8'(w[5]); bus.p6 = 8'(w[6]); bus.p7 = 8'(w[7]); bus.p8 = 8'(w[8]);
        bus.threshold = 8'(thr);
        m = ref_mag(w);
        if (!rn) begin
            q.delete();
            q.push_back(z);
            q.push_back(z);
        end else begin
            q.push_back('{v: v, r: v && (m > thr), m: m});
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({tag, ".out_valid"}, int'(bus.out_valid), int'(e.v));
        check({tag, ".result"}, int'(bus.result), int'(e.r));
`ifdef SOBEL_MAG_OUT_EN
        check({tag, ".magnitude"}, int'(bus.magnitude), e.m);
`endif
    endtask

    initial begin
        win_t w;
        int   c;
        q.push_back('{v: 1'b0, r: 1'b0, m: 0});
        for (int i = 0; i < 3; i++) cyc("reset", 1'b0, 1'b1, rand_win(), 0);

        w = '{'h1E, 'h35, 'hAE, 'h01, 0, 'hFF, 'h00, 'h1F, 'hFF};
        cyc("known914", 1'b1, 1'b1, w, 200);
        w = '{default: 'h80};
        cyc("flat", 1'b1, 1'b1, w, 0);
        c = int'($urandom_range(0, 255));
        w = '{0, c, 255, 0, c, 255, 0, c, 255};
        cyc("maxstep", 1'b1, 1'b1, w, 255);
        w = '{0, 0, 50, 0, 0, 50, 0, 0, 50};
        cyc("eq200", 1'b1, 1'b1, w, 200);
        cyc("eq199", 1'b1, 1'b1, w, 199);
        w = '{default: 0};
        cyc("zero", 1'b1, 1'b1, w, 0);
        cyc("flush", 1'b1, 1'b0, w, 0);
        cyc("flush", 1'b1, 1'b0, w, 0);

        for (int i = 0; i < 10; i++) cyc("burst1", 1'b1, 1'b1, rand_win(), int'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++)  cyc("gap", 1'b1, 1'b0, rand_win(), int'($urandom_range(0, 255)));
        for (int i = 0; i < 5; i++)  cyc("burst2", 1'b1, 1'b1, rand_win(), int'($urandom_range(0, 255)));

        for (int i = 0; i < 4; i++) cyc("pre_rst", 1'b1, 1'b1, rand_win(), int'($urandom_range(0, 100)));
        cyc("mid_rst", 1'b0, 1'b1, rand_win(), 0);
        for (int i = 0; i < 40; i++)
            cyc("random", 1'b1, 1'($urandom_range(0, 1)), rand_win(), int'($urandom_range(0, 255)));
        cyc("tail", 1'b1, 1'b0, rand_win(), 0);
        cyc("tail", 1'b1, 1'b0, rand_win(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
